// File: rtl/baud_tick_arbiter.sv
// ---------------------------------------------------------------------------
// baud_tick_arbiter
//
// Time-shares the UART's single baud-rate generator between the receiver and
// the transmitter (half-duplex). One requester owns the timebase at a time.
// On grant the generator is restarted at the phase the owner needs. The
// oversampled generator ticks are then divided into per-bit strobes for the
// owner.
//
// Handshake: rx_req/tx_req are levels. A request is held pending for as long
// as it stays high. The grant rises the cycle after the request is seen in
// IDLE. The grant stays high until the edge after the owner's 1-cycle done
// pulse. At least one IDLE cycle always separates two grants.
//
// Optional feature (compile macro BAUD_ARB_TIMEOUT_EN):
//   An owner that holds the grant for TIMEOUT_BITS bit periods is forced off.
//   arb_timeout pulses once when this happens. That requester is then masked
//   until its req drops. Without the macro, arb_timeout is tied to 0.
//
// Parameters:
//   SAMPLE_RATE   generator ticks per bit (even, >= 4)
//   TIMEOUT_BITS  bit periods before forced release (timeout build only)
//
// Ports:
//   clock         system clock, rising edge
//   reset_n       asynchronous active-low reset
//   brg_tick      oversample tick from the baud generator
//   brg_start_rx  restart generator at half-period phase (1-cycle pulse)
//   brg_start_tx  restart generator at zero phase (1-cycle pulse)
//   rx_req        RX needs the timebase (level)
//   rx_done       RX releases the timebase (pulse)
//   rx_gnt        RX owns the timebase
//   rx_bit_tick   mid-bit sample strobe for RX
//   tx_req        TX needs the timebase (level)
//   tx_done       TX releases the timebase (pulse)
//   tx_gnt        TX owns the timebase
//   tx_bit_tick   bit-boundary strobe for TX
//   arb_timeout   forced-release pulse
// ---------------------------------------------------------------------------
module baud_tick_arbiter #(
  parameter int SAMPLE_RATE  = 16,
  parameter int TIMEOUT_BITS = 12
) (
  input  logic clock,
  input  logic reset_n,
  input  logic brg_tick,
  output logic brg_start_rx,
  output logic brg_start_tx,
  input  logic rx_req,
  input  logic rx_done,
  output logic rx_gnt,
  output logic rx_bit_tick,
  input  logic tx_req,
  input  logic tx_done,
  output logic tx_gnt,
  output logic tx_bit_tick,
  output logic arb_timeout
);

  localparam int SW = $clog2(SAMPLE_RATE);
  localparam int BW = $clog2(TIMEOUT_BITS + 1);

  localparam logic [SW-1:0] SAMPLE_HALF = SW'(SAMPLE_RATE / 2);
  localparam logic [SW-1:0] SAMPLE_LAST = SW'(SAMPLE_RATE - 1);
  localparam logic [BW-1:0] BIT_MAX     = '1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RX_START  = 3'd1,
    ST_RX_ACTIVE = 3'd2,
    ST_TX_START  = 3'd3,
    ST_TX_ACTIVE = 3'd4
  } state_e;

  state_e        state_q, state_d;
  logic [SW-1:0] sample_q, sample_d;
  logic [BW-1:0] bit_q, bit_d;

  logic active;
  logic strobe;
  logic timeout_hit;
  logic rx_req_eff;
  logic tx_req_eff;

  assign active = (state_q == ST_RX_ACTIVE) || (state_q == ST_TX_ACTIVE);
  // The owner's strobe is combinational, so it lands in the same cycle as
  // the generator tick that completes the period.
  assign strobe = brg_tick && (sample_q == SAMPLE_LAST);

`ifdef BAUD_ARB_TIMEOUT_EN
  localparam logic [BW-1:0] BIT_LIMIT = BW'(TIMEOUT_BITS);

  logic mask_rx_q, mask_rx_d;
  logic mask_tx_q, mask_tx_d;

  // The bit counter reaches the limit on the terminal strobe edge. The
  // forced release therefore happens in the following cycle.
  assign timeout_hit = active && (bit_q == BIT_LIMIT);
  assign rx_req_eff  = rx_req && !mask_rx_q;
  assign tx_req_eff  = tx_req && !mask_tx_q;

  // The mask holds off a timed-out requester until it deasserts its req.
  // This keeps it from starving the other side.
  always_comb begin
    mask_rx_d = mask_rx_q;
    mask_tx_d = mask_tx_q;
    if (!rx_req) begin
      mask_rx_d = 1'b0;
    end else if (timeout_hit && (state_q == ST_RX_ACTIVE)) begin
      mask_rx_d = 1'b1;
    end
    if (!tx_req) begin
      mask_tx_d = 1'b0;
    end else if (timeout_hit && (state_q == ST_TX_ACTIVE)) begin
      mask_tx_d = 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_rx_q <= 1'b0;
      mask_tx_q <= 1'b0;
    end else begin
      mask_rx_q <= mask_rx_d;
      mask_tx_q <= mask_tx_d;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign rx_req_eff  = rx_req;
  assign tx_req_eff  = tx_req;
`endif

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state. RX wins a tie because start-bit timing cannot be deferred.
  // A done pulse from the non-owner is ignored.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (rx_req_eff) begin
          state_d = ST_RX_START;
        end else if (tx_req_eff) begin
          state_d = ST_TX_START;
        end
      end
      ST_RX_START:  state_d = rx_done ? ST_IDLE : ST_RX_ACTIVE;
      ST_RX_ACTIVE: if (rx_done || timeout_hit) state_d = ST_IDLE;
      ST_TX_START:  state_d = tx_done ? ST_IDLE : ST_TX_ACTIVE;
      ST_TX_ACTIVE: if (tx_done || timeout_hit) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    rx_gnt       = 1'b0;
    tx_gnt       = 1'b0;
    brg_start_rx = 1'b0;
    brg_start_tx = 1'b0;
    rx_bit_tick  = 1'b0;
    tx_bit_tick  = 1'b0;
    arb_timeout  = timeout_hit;
    case (state_q)
      ST_RX_START: begin
        rx_gnt       = 1'b1;
        brg_start_rx = 1'b1;
      end
      ST_RX_ACTIVE: begin
        rx_gnt      = 1'b1;
        rx_bit_tick = strobe;
      end
      ST_TX_START: begin
        tx_gnt       = 1'b1;
        brg_start_tx = 1'b1;
      end
      ST_TX_ACTIVE: begin
        tx_gnt      = 1'b1;
        tx_bit_tick = strobe;
      end
      default: ;
    endcase
  end

  // Sample / bit counters. RX preloads half a period, so its first strobe
  // falls mid start bit. TX starts from zero, so its strobes mark bit
  // boundaries. Ticks in a START state are ignored. The bit counter
  // saturates instead of wrapping.
  always_comb begin
    sample_d = sample_q;
    bit_d    = bit_q;
    case (state_q)
      ST_RX_START: begin
        sample_d = SAMPLE_HALF;
        bit_d    = '0;
      end
      ST_TX_START: begin
        sample_d = '0;
        bit_d    = '0;
      end
      ST_RX_ACTIVE, ST_TX_ACTIVE: begin
        if (brg_tick) begin
          if (sample_q == SAMPLE_LAST) begin
            sample_d = '0;
            if (bit_q != BIT_MAX) bit_d = bit_q + 1'b1;
          end else begin
            sample_d = sample_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sample_q <= '0;
      bit_q    <= '0;
    end else begin
      sample_q <= sample_d;
      bit_q    <= bit_d;
    end
  end

endmodule

// File: tb/tb_baud_tick_arbiter.sv
// ---------------------------------------------------------------------------
// tb_baud_tick_arbiter
//
// Self-checking bench for baud_tick_arbiter. The driver applies one set of
// inputs per cycle, shortly after the rising edge. For every cycle, the
// reference model pushes the expected output vector into exp_q. A monitor
// samples the DUT on the falling edge and compares the sampled outputs
// against the front of the queue.
//
// The reference model is transaction level. It tracks the current owner,
// the number of generator ticks since the grant, and the number of strobes
// issued. Strobe positions follow from tick-count arithmetic: an RX strobe
// falls on tick SR/2 + k*SR, and a TX strobe falls on tick k*SR.
// ---------------------------------------------------------------------------
module tb_baud_tick_arbiter;

  localparam int SR = 16;
  localparam int TB = 12;
`ifdef BAUD_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock    = 1'b0;
  logic reset_n  = 1'b0;
  logic brg_tick = 1'b0;
  logic rx_req   = 1'b0;
  logic rx_done  = 1'b0;
  logic tx_req   = 1'b0;
  logic tx_done  = 1'b0;

  logic brg_start_rx, brg_start_tx;
  logic rx_gnt, rx_bit_tick, tx_gnt, tx_bit_tick, arb_timeout;

  always #5 clock = ~clock;

  baud_tick_arbiter #(
    .SAMPLE_RATE (SR),
    .TIMEOUT_BITS(TB)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .brg_tick    (brg_tick),
    .brg_start_rx(brg_start_rx),
    .brg_start_tx(brg_start_tx),
    .rx_req      (rx_req),
    .rx_done     (rx_done),
    .rx_gnt      (rx_gnt),
    .rx_bit_tick (rx_bit_tick),
    .tx_req      (tx_req),
    .tx_done     (tx_done),
    .tx_gnt      (tx_gnt),
    .tx_bit_tick (tx_bit_tick),
    .arb_timeout (arb_timeout)
  );

  // ---------------- scoreboard ----------------
  // Vector order: {rx_gnt, tx_gnt, start_rx, start_tx, rx_bit, tx_bit, timeout}
  logic [6:0] exp_q[$];
  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // ---------------- reference model state ----------------
  int owner     = 0;    // 0 none, 1 rx, 2 tx
  bit starting  = 1'b0;
  int ticks     = 0;    // generator ticks seen since the grant
  int strobes   = 0;    // bit strobes issued since the grant
  bit mask_rx   = 1'b0;
  bit mask_tx   = 1'b0;

  // One clock cycle: apply inputs, predict outputs, advance the model.
  task automatic step(input bit rst_n_v, input bit rxr, input bit rxd,
                      input bit txr, input bit txd, input bit tk);
    bit rx_g, tx_g, st_rx, st_tx, rbt, tbt, tmo, is_strobe, own_done;
    int nt, old_owner;
    @(posedge clock);
    #1;
    reset_n  = rst_n_v;
    rx_req   = rxr;
    rx_done  = rxd;
    tx_req   = txr;
    tx_done  = txd;
    brg_tick = tk;
    cyc++;

    rx_g = 0; tx_g = 0; st_rx = 0; st_tx = 0; rbt = 0; tbt = 0; tmo = 0;
    is_strobe = 0;
    nt = ticks + (tk ? 1 : 0);
    if (rst_n_v && owner != 0) begin
      rx_g = (owner == 1);
      tx_g = (owner == 2);
      if (starting) begin
        st_rx = (owner == 1);
        st_tx = (owner == 2);
      end else begin
        if (tk) is_strobe = (owner == 1) ? (((nt + SR / 2) % SR) == 0)
                                          : ((nt % SR) == 0);
        rbt = is_strobe && (owner == 1);
        tbt = is_strobe && (owner == 2);
        tmo = TO_EN && (strobes == TB);
      end
    end
    exp_q.push_back({rx_g, tx_g, st_rx, st_tx, rbt, tbt, tmo});

    if (!rst_n_v) begin
      owner = 0; starting = 0; ticks = 0; strobes = 0;
      mask_rx = 0; mask_tx = 0;
    end else begin
      old_owner = owner;
      own_done  = (owner == 1 && rxd) || (owner == 2 && txd);
      if (owner == 0) begin
        if (rxr && !mask_rx) begin
          owner = 1; starting = 1;
        end else if (txr && !mask_tx) begin
          owner = 2; starting = 1;
        end
      end else if (starting) begin
        if (own_done) owner = 0;
        starting = 0; ticks = 0; strobes = 0;
      end else begin
        ticks = nt;
        if (is_strobe && strobes < 1000) strobes++;
        if (own_done || tmo) owner = 0;
      end
      if (!rxr) mask_rx = 0;
      else if (tmo && old_owner == 1) mask_rx = 1;
      if (!txr) mask_tx = 0;
      else if (tmo && old_owner == 2) mask_tx = 1;
    end
  endtask

  // n cycles with fixed request levels and a tick every 'period' cycles.
  task automatic run(input int n, input bit rxr, input bit txr, input int period);
    for (int i = 0; i < n; i++) step(1'b1, rxr, 1'b0, txr, 1'b0, (i % period) == (period - 1));
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (exp_q.size() > 0) begin
      logic [6:0] e;
      logic [6:0] a;
      e = exp_q.pop_front();
      a = {rx_gnt, tx_gnt, brg_start_rx, brg_start_tx, rx_bit_tick, tx_bit_tick, arb_timeout};
      checks++;
      if (a === e) passes++;
      else $display("FAIL outputs cycle %0d {rx_gnt,tx_gnt,start_rx,start_tx,rx_bit,tx_bit,timeout} got %b expected %b",
                    cyc, a, e);
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    bit rxr, txr, rxd, txd, tk, rst;

    // Reset held with both requests high: all outputs stay 0.
    repeat (3) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);

    // Release: RX is granted, then ticks every cycle (strobes on 8, 24, 40).
    run(46, 1'b1, 1'b1, 1);
    // rx_done with rx_req still high: release, one IDLE cycle, re-grant.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    run(4, 1'b1, 1'b1, 1);
    // Stray tx_done while RX owns the timebase.
    step(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    run(3, 1'b1, 1'b1, 1);
    // RX releases and drops its request; the pending TX is granted.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    // TX with a tick every 3 cycles (strobes on ticks 16, 32).
    run(110, 1'b0, 1'b1, 3);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1);

    // Contention: both requests rise together; RX wins; handover after 3 bits.
    run(42, 1'b1, 1'b1, 1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    run(20, 1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1);

    // RX never sends done, with TX pending.
    run(12 * SR + 30, 1'b1, 1'b1, 1);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    run(10, 1'b1, 1'b0, 1);
    run(2, 1'b0, 1'b0, 1);
    run(10, 1'b1, 1'b0, 1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    run(2, 1'b0, 1'b0, 1);

    // Reset in the middle of a TX frame, then re-request.
    run(20, 1'b0, 1'b1, 1);
    repeat (2) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run(5, 1'b0, 1'b0, 1);
    run(10, 1'b0, 1'b1, 1);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0, 1);

    // Randomized traffic: frequent, then rare, done pulses.
    rxr = 0;
    txr = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 29) == 0) rxr = !rxr;
      if ($urandom_range(0, 29) == 0) txr = !txr;
      rxd = ($urandom_range(0, (i < 2000) ? 40 : 400) == 0);
      txd = ($urandom_range(0, (i < 2000) ? 40 : 400) == 0);
      tk  = ($urandom_range(0, 1) == 1);
      rst = ($urandom_range(0, 999) != 0);
      step(rst, rxr, rxd, txr, txd, tk);
    end
    run(3, 1'b0, 1'b0, 1);

    @(negedge clock);
    @(negedge clock);
    checks++;
    if (exp_q.size() == 0) passes++;
    else $display("FAIL drain leftover expectations got %0d required 0", exp_q.size());

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/baud_tick_arbiter.md
# baud_tick_arbiter

Owns the UART's single baud-rate generator and time-shares it between the receiver and transmitter in half-duplex. It grants the timebase to one requester at a time and pulses the generator's RX-phase or TX-phase restart. It then divides the oversampled generator ticks into per-bit strobes for the current owner. It sits between the baud-rate generator and the UART RX/TX engines.

## Interface
- SAMPLE_RATE, 16: generator ticks per bit; even, ≥4.
- TIMEOUT_BITS, 12: bit periods an owner may hold the grant (only with the timeout feature).

- clock  in  1  system clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- brg_tick  in  1  oversample tick from baud generator (1-cycle pulse)
- brg_start_rx  out  1  1-cycle pulse: restart generator at half-period phase
- brg_start_tx  out  1  1-cycle pulse: restart generator at zero phase
- rx_req  in  1  level; RX engine saw start-bit edge and needs timebase
- rx_done  in  1  1-cycle pulse; RX releases timebase
- rx_gnt  out  1  RX owns timebase
- rx_bit_tick  out  1  mid-bit sample strobe for RX
- tx_req  in  1  level; TX engine has a frame to send
- tx_done  in  1  1-cycle pulse; TX releases timebase
- tx_gnt  out  1  TX owns timebase
- tx_bit_tick  out  1  bit-boundary strobe for TX
- arb_timeout  out  1  1-cycle pulse on forced release (0 when feature compiled out)

## Operation
- FSM states: IDLE, RX_START, RX_ACTIVE, TX_START, TX_ACTIVE.
- IDLE: if unmasked rx_req, go RX_START; else if unmasked tx_req, go TX_START. RX wins simultaneous requests, because start-bit timing cannot be deferred.
- RX_START (1 cycle): brg_start_rx=1, rx_gnt=1, sample counter loaded with SAMPLE_RATE/2, bit counter cleared; go RX_ACTIVE.
- TX_START (1 cycle): brg_start_tx=1, tx_gnt=1, sample counter loaded with 0, bit counter cleared; go TX_ACTIVE.
- brg_tick in a START state is ignored.
- ACTIVE: on brg_tick, if sample counter == SAMPLE_RATE-1, pulse owner's bit_tick (same cycle, combinational from the counter and brg_tick), clear the counter and increment the bit counter; otherwise increment the sample counter.
  - Result: RX first strobe after SAMPLE_RATE/2 ticks (middle of start bit), then every SAMPLE_RATE.
  - TX first strobe after SAMPLE_RATE ticks, then every SAMPLE_RATE.
- Owner's done pulse returns FSM to IDLE next edge. done wins over a still-high req in the same cycle.
- A req with no grant that stays high is held pending. No preemption: tx_req during RX_ACTIVE waits.
- Non-owner done pulses are ignored. Non-owner bit_tick is always 0.
- Sample counter width $clog2(SAMPLE_RATE). Bit counter width $clog2(TIMEOUT_BITS+1); it saturates, never wraps.

## Timing
- Reset (async assert, sync release): state IDLE; all counters and masks 0; every output 0.
- Grant latency: req high at edge N in IDLE → gnt and start pulse high in cycle after N. gnt stays high until the edge after done.
- After release, at least one IDLE cycle precedes the next grant. Back-to-back handover is therefore done → 1 IDLE cycle → START.
- rx_gnt and tx_gnt are never both 1. brg_start_rx and brg_start_tx are never both 1.
- Reset mid-frame: grant drops immediately, and no start pulse is issued until re-request after reset release.

## Configuration
- BAUD_ARB_TIMEOUT_EN defined:
  - When the bit counter reaches TIMEOUT_BITS in ACTIVE, FSM returns to IDLE and arb_timeout pulses for 1 cycle (cycle after the terminal bit_tick).
  - The timed-out requester is masked until its req deasserts, so the other side is not starved.
- Undefined: no timeout logic or mask. arb_timeout tied 0. Owner holds the grant until done.

## Test plan
- Reset: reset_n=0 with rx_req=tx_req=1 → all outputs 0; release → rx_gnt rises 1 cycle later with a single brg_start_rx pulse.
- RX strobes, SAMPLE_RATE=16: grant RX, drive brg_tick every cycle → rx_bit_tick on ticks 8, 24, 40; tx_bit_tick stays 0.
- TX strobes: grant TX, brg_tick every 3 cycles → tx_bit_tick on ticks 16, 32; brg_start_tx pulses exactly once.
- Contention: rx_req and tx_req rise same cycle → RX granted. rx_done after 3 bits → 1 IDLE cycle, then tx_gnt plus brg_start_tx; grants never overlap.
- Done/req collision and stray done: tx_done pulsed during RX_ACTIVE → ignored. rx_done with rx_req still high → release, 1 IDLE cycle, re-grant.
- Timeout, with BAUD_ARB_TIMEOUT_EN, TIMEOUT_BITS=12: RX never sends done → arb_timeout pulse after the 12th rx_bit_tick. Pending tx_req is granted next; RX is not re-granted until rx_req toggles low. Without the macro, the grant persists past 12 bits and arb_timeout stays 0.
